// File: rtl/ram_rd_credit_reader_pkg.sv
// ram_rd_pkg: shared types and default sizes for the credit-gated RAM burst reader.
//   rd_state_t     : reader FSM states (FLUSH, IDLE, RUN)
//   *_DEF          : default ADDR_W / DATA_W / RD_LATENCY / FIFO_DEPTH
//   cred_width()   : bits needed to hold a credit count of 0..depth
// Optional feature macro used by the top: RD_READER_STAT_EN.
package ram_rd_pkg;

  localparam int ADDR_W_DEF     = 8;
  localparam int DATA_W_DEF     = 16;
  localparam int RD_LATENCY_DEF = 4;
  localparam int FIFO_DEPTH_DEF = 8;

  // Credits run from 0 to FIFO_DEPTH inclusive, hence the +1.
  function automatic int cred_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int CRED_W = cred_width(FIFO_DEPTH_DEF);

  typedef enum logic [1:0] {
    FLUSH = 2'd0,
    IDLE  = 2'd1,
    RUN   = 2'd2
  } rd_state_t;

endpackage

// File: rtl/ram_rd_credit_reader_if.sv
// ram_rd_credit_reader_if: command and output-stream bundle of the burst reader.
//   cmd_valid/cmd_ready/cmd_addr/cmd_len : burst command (len 0..2**ADDR_W)
//   out_data/out_valid/out_ready/out_last : returned word stream
// Handshake rule for both channels: a transfer happens in exactly the cycles
// where valid and ready are both high at the rising clock edge; the producer
// holds valid and its payload stable until that transfer, and ready may be
// raised or dropped at any time without waiting for valid.
// Modports: slave = reader side, master = command issuer / stream sink.
interface ram_rd_credit_reader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W:0]   cmd_len;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, out_ready,
    output cmd_ready, out_data, out_valid, out_last
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_len, out_ready,
    input  cmd_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/ram_rd_credit_reader_rd_ret_fifo.sv
// rd_ret_fifo: synchronous return-data FIFO, DATA_W x DEPTH (DEPTH power of 2).
//   clk, rstp          : clock, synchronous active-high clear (pointers/count)
//   push, push_data    : write one word (no full flag; the caller's credit
//                        scheme guarantees there is always room)
//   pop                : consume the head word (ignored when empty)
//   head_valid, head_data : show-ahead head, both derived from registers
module rd_ret_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rstp,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              head_valid,
  output logic [DATA_W-1:0] head_data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              do_pop;

  assign do_pop     = pop && (count != '0);
  assign head_valid = (count != '0);
  assign head_data  = mem[rd_ptr];

  // Storage has no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rstp) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/ram_rd_credit_reader.sv
// ram_rd_credit_reader: burst read master for a fixed-latency RAM read port.
// A command (addr, len) is turned into len back-to-back rd_read strobes with
// wrapping addresses; returned words land in a local FIFO and leave on the
// out_* stream. The RAM cannot be stalled, so a read is only issued while a
// credit (a guaranteed free FIFO slot) is available.
// Ports:
//   clk, rstp               : clock, synchronous active-high reset
//   bus (slave modport)     : cmd_* command channel, out_* stream channel
//   rd_addr, rd_read        : RAM read request
//   rd_data, rd_valid       : RAM read return, RD_LATENCY cycles after rd_read
//   busy                    : command in progress (also high during FLUSH)
//   done                    : one-cycle pulse when the final word is popped
//   stall_cnt, stat_clr     : only with RD_READER_STAT_EN defined; counts RUN
//                             cycles blocked on credits, saturating at 0xFFFF
//   dbg_state, dbg_credits  : FSM state and credit counter for observation
module ram_rd_credit_reader
  import ram_rd_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_LATENCY = RD_LATENCY_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                                clk,
  input  logic                                rstp,
  ram_rd_credit_reader_if.slave               bus,
  output logic [ADDR_W-1:0]                   rd_addr,
  output logic                                rd_read,
  input  logic [DATA_W-1:0]                   rd_data,
  input  logic                                rd_valid,
  output logic                                busy,
  output logic                                done,
`ifdef RD_READER_STAT_EN
  output logic [15:0]                         stall_cnt,
  input  logic                                stat_clr,
`endif
  output rd_state_t                           dbg_state,
  output logic [cred_width(FIFO_DEPTH)-1:0]   dbg_credits
);
  localparam int CW = cred_width(FIFO_DEPTH);
  localparam int FW = $clog2(RD_LATENCY + 1);

  rd_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   issue_q;
  logic [ADDR_W:0]   pop_q;
  logic [CW-1:0]     cred_q;
  logic [FW-1:0]     flush_q;
  logic              zero_done_q;

  logic              accept;
  logic              issue;
  logic              pop;
  logic              fifo_push;
  logic              head_valid;
  logic [DATA_W-1:0] head_data;
  logic              last_pop;

  assign accept    = bus.cmd_valid && (state_q == IDLE);
  assign issue     = (state_q == RUN) && (issue_q != '0) && (cred_q != '0);
  assign pop       = head_valid && bus.out_ready;
  // Returns outside RUN are leftovers from an abandoned burst (FLUSH) or a
  // protocol error (IDLE); neither may reach the FIFO.
  assign fifo_push = rd_valid && (state_q == RUN);
  assign last_pop  = pop && (pop_q == (ADDR_W+1)'(1));

  assign bus.cmd_ready = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign rd_read       = issue;
  assign rd_addr       = addr_q;
  assign bus.out_valid = head_valid;
  // Gate the data so the stream reads as zero while nothing is valid.
  assign bus.out_data  = head_valid ? head_data : '0;
  assign bus.out_last  = head_valid && (state_q == RUN) && (pop_q == (ADDR_W+1)'(1));
  assign dbg_state     = state_q;
  assign dbg_credits   = cred_q;

  rd_ret_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rstp       (rstp),
    .push       (fifo_push),
    .push_data  (rd_data),
    .pop        (pop),
    .head_valid (head_valid),
    .head_data  (head_data)
  );

  always_comb begin
    state_d = state_q;
    done    = zero_done_q;
    case (state_q)
      FLUSH: begin
        if (flush_q == FW'(RD_LATENCY - 1)) state_d = IDLE;
      end
      IDLE: begin
        // A zero-length command completes without leaving IDLE.
        if (accept && (bus.cmd_len != '0)) state_d = RUN;
      end
      RUN: begin
        if (last_pop) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = FLUSH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstp) begin
      state_q     <= FLUSH;
      flush_q     <= '0;
      addr_q      <= '0;
      issue_q     <= '0;
      pop_q       <= '0;
      cred_q      <= CW'(FIFO_DEPTH);
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      zero_done_q <= accept && (bus.cmd_len == '0);
      flush_q     <= (state_q == FLUSH) ? flush_q + FW'(1) : '0;
      if (accept) begin
        addr_q  <= bus.cmd_addr;
        issue_q <= bus.cmd_len;
        pop_q   <= bus.cmd_len;
      end else begin
        if (issue) begin
          addr_q  <= addr_q + ADDR_W'(1);
          issue_q <= issue_q - (ADDR_W+1)'(1);
        end
        if (pop) pop_q <= pop_q - (ADDR_W+1)'(1);
      end
      // A read consumes a slot, a pop frees one; both together cancel out.
      case ({issue, pop})
        2'b10:   cred_q <= cred_q - CW'(1);
        2'b01:   cred_q <= cred_q + CW'(1);
        default: cred_q <= cred_q;
      endcase
    end
  end

`ifdef RD_READER_STAT_EN
  logic stall;
  assign stall = (state_q == RUN) && (issue_q != '0) && (cred_q == '0);

  always_ff @(posedge clk) begin
    if (rstp || stat_clr) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  rd_valid_in_idle_a: assert property (@(posedge clk) disable iff (rstp)
    !(rd_valid && (state_q == IDLE)));
  cred_bound_a: assert property (@(posedge clk) disable iff (rstp)
    cred_q <= CW'(FIFO_DEPTH));
`endif
endmodule

// File: tb/tb_ram_rd_credit_reader.sv
// tb_ram_rd_credit_reader: bench pairing the reader with a 256x16 RAM model
// (mem[i] = 16'hA000 + i, fixed read latency). Expected words and read
// addresses are queued when a command is issued; a negedge monitor pops and
// compares whenever the DUT reads or delivers a word.
module tb_ram_rd_credit_reader;
  import ram_rd_pkg::*;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 16;
  localparam int RD_LATENCY = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int CW         = $clog2(FIFO_DEPTH + 1);

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstp = 1'b1;
  int   cyc  = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_read;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;
  logic              done;
  rd_state_t         dbg_state;
  logic [CW-1:0]     dbg_credits;
`ifdef RD_READER_STAT_EN
  logic [15:0]       stall_cnt;
  logic              stat_clr = 1'b0;
`endif

  ram_rd_credit_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_rd_credit_reader #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .RD_LATENCY (RD_LATENCY),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .rstp        (rstp),
    .bus         (bus),
    .rd_addr     (rd_addr),
    .rd_read     (rd_read),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .busy        (busy),
    .done        (done),
`ifdef RD_READER_STAT_EN
    .stall_cnt   (stall_cnt),
    .stat_clr    (stat_clr),
`endif
    .dbg_state   (dbg_state),
    .dbg_credits (dbg_credits)
  );

  // ---------------- RAM model (not reset: in-flight reads survive rstp) ----------------
  logic [DATA_W-1:0]     mem [256];
  logic [RD_LATENCY-1:0] pv = '0;
  logic [ADDR_W-1:0]     pa [RD_LATENCY];

  initial for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);

  always @(posedge clk) begin
    pv    <= {pv[RD_LATENCY-2:0], rd_read};
    pa[0] <= rd_addr;
    for (int i = 1; i < RD_LATENCY; i++) pa[i] <= pa[i-1];
  end
  assign rd_valid = pv[RD_LATENCY-1];
  assign rd_data  = pv[RD_LATENCY-1] ? mem[pa[RD_LATENCY-1]] : 16'h0;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [DATA_W:0]   exp_q [$];   // {last, data}
  logic [ADDR_W-1:0] addr_q [$];
  logic [DATA_W:0]   e;
  int read_cnt   = 0;
  int done_cnt   = 0;
  int done_exp   = 0;
  int model_cred = FIFO_DEPTH;
  int first_pop_cyc = 0;
  bit first_seen = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Credits modelled as FIFO_DEPTH minus words read but not yet popped.
  always @(negedge clk) begin
    if (rstp) begin
      model_cred = FIFO_DEPTH;
    end else begin
      check("credits", dbg_credits, model_cred);
      if (rd_read) begin
        read_cnt++;
        check("read_with_credit", model_cred > 0, 1);
        check("read_expected", addr_q.size() != 0, 1);
        if (addr_q.size() != 0) check("rd_addr", rd_addr, addr_q.pop_front());
      end
      if (done) done_cnt++;
      if (bus.out_valid) check("valid_has_expected", exp_q.size() != 0, 1);
      if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
        if (!first_seen) begin
          first_seen    = 1'b1;
          first_pop_cyc = cyc;
        end
        e = exp_q.pop_front();
        check("out_data", bus.out_data, e[DATA_W-1:0]);
        check("out_last", bus.out_last, e[DATA_W]);
        check("done_on_last", done, e[DATA_W]);
      end
      model_cred = model_cred - int'(rd_read) + int'(bus.out_valid && bus.out_ready);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [7:0] a, input int len, output int acc_cyc);
    int guard = 0;
    while (!bus.cmd_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    check("cmd_ready_wait", bus.cmd_ready, 1);
    for (int i = 0; i < len; i++) begin
      exp_q.push_back({(i == len - 1), 16'hA000 + 16'((int'(a) + i) % 256)});
      addr_q.push_back(8'((int'(a) + i) % 256));
    end
    done_exp++;
    first_seen    = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_len   = 9'(len);
    acc_cyc       = cyc;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input bit rand_ready);
    int n = 0;
    while (done_cnt != done_exp && n < max_cyc) begin
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    check("done_reached", done_cnt, done_exp);
    check("words_left", exp_q.size(), 0);
    bus.out_ready = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc;
    int rc0;
    int n;
    int a;
    int len;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.out_ready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1);
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_rd_read", rd_read, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_done", done, 0);
    check("rst_credits", dbg_credits, FIFO_DEPTH);
    check("rst_state", int'(dbg_state), int'(FLUSH));
`ifdef RD_READER_STAT_EN
    check("rst_stall_cnt", stall_cnt, 0);
`endif
    @(posedge clk); #1;
    rstp = 1'b0;
    // FLUSH holds for RD_LATENCY cycles after reset release
    for (int i = 0; i < RD_LATENCY; i++) begin
      @(negedge clk);
      check("flush_hold", bus.cmd_ready, 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("flush_exit", bus.cmd_ready, 1);
    check("idle_busy", busy, 0);
    @(posedge clk); #1;

    // 1) addr 0x10 len 4, steady ready; first pop RD_LATENCY+2 after accept
    send_cmd(8'h10, 4, acc);
    wait_done(50, 1'b0);
    check("first_pop_latency", first_pop_cyc - acc, RD_LATENCY + 2);

    // 2) address wrap 0xFE..0x01
    send_cmd(8'hFE, 4, acc);
    wait_done(50, 1'b0);

    // 3) len 20 with out_ready low: exactly FIFO_DEPTH reads, then stall
    bus.out_ready = 1'b0;
    rc0 = read_cnt;
    send_cmd(8'h30, 20, acc);
    repeat (18) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("stall_reads", read_cnt - rc0, FIFO_DEPTH);
    check("stall_credits", dbg_credits, 0);
    check("stall_out_valid", bus.out_valid, 1);
`ifdef RD_READER_STAT_EN
    check("stall_cnt_10", stall_cnt, 10);
`endif
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_done(100, 1'b0);
`ifdef RD_READER_STAT_EN
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    @(negedge clk);
    check("stall_cnt_clr", stall_cnt, 0);
    @(posedge clk); #1;
`endif

    // 4) len 0: done the cycle after accept, still ready, no reads
    rc0 = read_cnt;
    send_cmd(8'h55, 0, acc);
    @(negedge clk);
    check("len0_done", done, 1);
    check("len0_cmd_ready", bus.cmd_ready, 1);
    check("len0_busy", busy, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("len0_done_pulse", done, 0);
    check("len0_no_read", read_cnt - rc0, 0);
    wait_done(10, 1'b0);

    // 5) reset with reads in flight: stale returns must be dropped
    rc0 = read_cnt;
    send_cmd(8'h40, 8, acc);
    n = 0;
    while (read_cnt - rc0 < 3 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("inflight_reads", read_cnt - rc0 >= 3, 1);
    rstp = 1'b1;
    @(posedge clk); #1;
    rstp = 1'b0;
    exp_q.delete();
    addr_q.delete();
    done_exp--;
    @(negedge clk);
    check("midrst_state", int'(dbg_state), int'(FLUSH));
    for (int i = 0; i < 10; i++) begin
      check("midrst_out_valid", bus.out_valid, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    send_cmd(8'h20, 2, acc);
    wait_done(50, 1'b0);

    // Random commands with random back-pressure
    for (int k = 0; k < 8; k++) begin
      a   = $urandom_range(0, 255);
      len = $urandom_range(0, 40);
      send_cmd(8'(a), len, acc);
      wait_done(2000, 1'b1);
    end

    // Full-size command: len = 2**ADDR_W
    a = $urandom_range(0, 255);
    send_cmd(8'(a), 256, acc);
    wait_done(600, 1'b0);

    repeat (6) begin
      @(posedge clk); #1;
    end
    check("final_done_count", done_cnt, done_exp);
    check("final_queue_empty", exp_q.size() + addr_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute bound on the run
  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
